// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default frame geometry and
// the receiver state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // metastability filter: two back-to-back flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data capture, stop-bit check and a valid/ready output holding register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick16,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SCNT_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] SCNT_ONE  = SW'(1);
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SCNT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIDX_LAST = 3'(DATA_BITS - 1);

  rx_state_e              r_state;
  logic [SW-1:0]          r_scnt;
  logic [2:0]             r_bidx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;
  logic                   r_busy;

  logic                   w_rx_s;
  rx_state_e              w_state_nxt;
  logic [SW-1:0]          w_scnt_nxt;
  logic                   w_bidx_ld;
  logic                   w_bidx_clr;
  logic [2:0]             w_bidx_mux;
  logic                   w_shift_ld;
  logic                   w_done;
  logic                   w_ferr;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_bidx_mux = w_bidx_clr ? 3'd0 : (r_bidx + 3'd1);

  // next-state and datapath controls; counters move only on tick16
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bidx_ld   = 1'b0;
    w_bidx_clr  = 1'b0;
    w_shift_ld  = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_scnt_nxt  = SCNT_ZERO;
          w_bidx_ld   = 1'b1;
          w_bidx_clr  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (tick16) begin
          if (r_scnt == SCNT_MID) begin
            w_scnt_nxt = SCNT_ZERO;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_bidx_ld   = 1'b1;
              w_bidx_clr  = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_scnt_nxt = r_scnt + SCNT_ONE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (tick16) begin
          if (r_scnt == SCNT_END) begin
            w_scnt_nxt = SCNT_ZERO;
            w_shift_ld = 1'b1;
            w_bidx_ld  = 1'b1;
            if (r_bidx == BIDX_LAST) begin
              w_state_nxt = STOP;
              w_bidx_clr  = 1'b1;
            end else begin
              w_bidx_clr  = 1'b0;
            end
          end else begin
            w_scnt_nxt = r_scnt + SCNT_ONE;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (tick16) begin
          if (r_scnt == SCNT_END) begin
            w_scnt_nxt  = SCNT_ZERO;
            w_state_nxt = IDLE;
            if (w_rx_s) begin
              w_done = 1'b1;
            end else begin
              w_ferr = 1'b1;
            end
          end else begin
            w_scnt_nxt = r_scnt + SCNT_ONE;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_scnt_nxt  = SCNT_ZERO;
      end
    endcase
  end

  // all receiver state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_scnt  <= SCNT_ZERO;
      r_bidx  <= 3'd0;
      r_shift <= {DATA_BITS{1'b0}};
      r_data  <= {DATA_BITS{1'b0}};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      if (w_bidx_ld) begin
        r_bidx <= w_bidx_mux;
      end
      if (w_shift_ld) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
      r_ferr <= w_ferr;
      r_ovr  <= w_done && r_valid && !rx_ready;
      r_busy <= (w_state_nxt != IDLE);
      // a consumer handshake in the completion cycle frees the slot for the new byte
      if (w_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push expected bytes and
// error events; a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int TDIV = 4;
  localparam int BIT  = OS * TDIV;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick16 = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q_data[$];
  int         q_evt[$];
  int         tcnt = 0;
  logic [7:0] m_exp;
  int         m_kind;
  int         m_want;
  logic       m_pf = 1'b0;
  logic       m_po = 1'b0;
  logic       hit;
  logic [7:0] abort_byte;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick16    (tick16),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick16 = (tcnt == TDIV - 1);
      tcnt   = (tcnt + 1) % TDIV;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clk(BIT);
    end else begin
      rx = 1'b0;
      wait_clk(BIT * 3 / 4);
      rx = 1'b1;
      wait_clk(BIT - BIT * 3 / 4);
    end
  endtask

  // monitor: accepted bytes and one-clk error pulses against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        n_checks++;
        if (q_data.size() == 0) begin
          n_errors++;
          $display("FAIL accept: got byte 0x%02h, expected no byte", rx_data);
        end else begin
          m_exp = q_data.pop_front();
          if (rx_data !== m_exp) begin
            n_errors++;
            $display("FAIL accept: got byte 0x%02h, expected 0x%02h", rx_data, m_exp);
          end
        end
      end
      if (frame_err || overrun) begin
        n_checks++;
        m_kind = frame_err ? EV_FERR : EV_OVR;
        if (frame_err && overrun) begin
          n_errors++;
          $display("FAIL event: got frame_err=1 overrun=1, expected at most one");
        end else if (q_evt.size() == 0) begin
          n_errors++;
          $display("FAIL event: got kind %0d, expected no event", m_kind);
        end else begin
          m_want = q_evt.pop_front();
          if (m_kind != m_want) begin
            n_errors++;
            $display("FAIL event: got kind %0d, expected kind %0d", m_kind, m_want);
          end
        end
      end
      if ((frame_err && m_pf) || (overrun && m_po)) begin
        n_checks++;
        n_errors++;
        $display("FAIL pulse_width: got pulse longer than 1 clk, expected 1 clk");
      end
      m_pf = frame_err;
      m_po = overrun;
    end
  end

  initial begin
    wait_clk(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // plain frame, consumer always ready
    q_data.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clk(BIT);
    check("a5_busy_low", busy, 0);
    check("a5_valid_one_clk", rx_valid, 0);

    // short low glitch must be rejected at mid start bit
    rx = 1'b0;
    wait_clk(4 * TDIV);
    rx = 1'b1;
    wait_clk(BIT);
    check("glitch_busy_low", busy, 0);

    // bad stop bit
    q_evt.push_back(EV_FERR);
    send_frame(8'h3C, 1'b0);
    wait_clk(2 * BIT);
    check("ferr_valid_low", rx_valid, 0);
    check("ferr_data_kept", rx_data, 8'hA5);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    q_data.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_clk(2 * BIT);
    q_evt.push_back(EV_OVR);
    send_frame(8'h22, 1'b1);
    wait_clk(2 * BIT);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid_kept", rx_valid, 1);

    // ready asserted only in the completion cycle of the next frame
    q_data.push_back(8'h22);
    hit = 1'b0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int i = 0; i < BIT * 12 && !hit; i++) begin
          @(posedge clk);
          #2;
          if (dut.r_state == STOP && dut.r_scnt == 4'(OS - 1) && tick16 && dut.w_rx_s) begin
            rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    check("ready_window_found", hit, 1);
    wait_clk(BIT);
    check("swap_data", rx_data, 8'h22);
    check("swap_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_clk(4);

    // reset while receiving data bit 4
    abort_byte = 8'h5A;
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = abort_byte[i];
      wait_clk(BIT);
    end
    rx = abort_byte[4];
    wait_clk(16);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_rx_valid", rx_valid, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_frame_err", frame_err, 0);
    check("abort_overrun", overrun, 0);
    check("abort_busy", busy, 0);
    rx = 1'b1;
    wait_clk(BIT);
    rst_n = 1'b1;
    wait_clk(4);
    q_data.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_clk(2 * BIT);

    // back-to-back frames without idle gap
    q_data.push_back(8'h00);
    q_data.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(2 * BIT);
    check("end_busy_low", busy, 0);
    check("pending_bytes", q_data.size(), 0);
    check("pending_events", q_evt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning tick16 pulses per bit period (power of two, 8..16).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tick16  input  1  oversample enable strobe, one clk wide, OVERSAMPLE per bit time.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-008 rx_data  output  DATA_BITS  received byte, LSB first on line.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse: completed byte dropped because rx_valid still pending.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decisions use synchronized rx_s (2-clk latency).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; sample counter scnt (log2 OVERSAMPLE bits) and bit index bidx (3 bits) advance only on tick16.
REQ-015 IDLE: rx_s low -> START, scnt=0, bidx=0.
REQ-016 START: on tick16 with scnt==OVERSAMPLE/2-1, rx_s low -> DATA with scnt=0; rx_s high -> IDLE (glitch rejected, no outputs asserted).
REQ-017 DATA: on tick16 with scnt==OVERSAMPLE-1, shift rx_s into shift register MSB end (LSB-first reception), scnt wraps to 0; bidx increments, or -> STOP when bidx==DATA_BITS-1.
REQ-018 bidx next value SHALL be selected between bidx+1 and 0 by a 2:1 select (0 on entry to DATA and on exit to STOP).
REQ-019 STOP: on tick16 with scnt==OVERSAMPLE-1: rx_s high -> byte complete; rx_s low -> frame_err pulse, byte discarded; both -> IDLE next cycle.
REQ-020 Byte complete with rx_valid low, or with rx_valid high and rx_ready high same cycle: rx_data loaded, rx_valid high next cycle.
REQ-021 Byte complete with rx_valid high and rx_ready low: rx_data/rx_valid unchanged, overrun pulses one clk.
REQ-022 rx_valid SHALL clear the cycle after rx_valid && rx_ready (unless REQ-020 reloads); rx_data stable while rx_valid high.
REQ-023 Ticks in IDLE ignored; no tick16 -> FSM holds state and counters.
REQ-024 frame_err and overrun SHALL never be high simultaneously and never stay high beyond one clk.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, scnt=0, bidx=0, shift register 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops to 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulse; after release, reception restarts on next falling edge of rx_s.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enum type (IDLE/START/DATA/STOP) and default OVERSAMPLE/DATA_BITS constants.
REQ-028 One sub-module uart_rx_sync (2-flop synchronizer, reset to 1) SHALL be instantiated; rest in a single always_ff plus always_comb next-state.

Verification
REQ-029 Frame 0xA5, 8N1, OVERSAMPLE=16, rx_ready=1 -> rx_valid high one clk, rx_data=0xA5, busy low afterwards.
REQ-030 rx low for 4 ticks then high -> FSM back to IDLE, no rx_valid/frame_err.
REQ-031 Frame 0x3C with stop bit low -> frame_err one-clk pulse, rx_valid stays 0, rx_data unchanged.
REQ-032 Two frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, rx_valid=1, overrun pulse at second stop; rx_ready=1 same cycle as second completion -> rx_data=0x22, no overrun.
REQ-033 rst_n asserted mid-DATA (bidx=4) -> all outputs 0 immediately; next frame 0xFF received correctly.
REQ-034 Back-to-back frames 0x00, 0xFF with no idle gap -> both received in order, no errors.
